// File: rtl/ecc_pkg.sv
// Shared SEC-DED definitions: parity sizing, Hamming position mapping, encoder
// and the decode classification used by the FIFO read-path decoder.
package ecc_pkg;

  localparam int ECC_MAX_DW = 64;
  localparam int ECC_MAX_MW = 72;

  typedef enum logic [1:0] {
    ECC_CLEAN,
    ECC_SEC,
    ECC_DED
  } ecc_class_e;

  function automatic int calc_parity_bits(input int dataWidth);
    int p;
    p = 1;
    while ((1 << p) < dataWidth + p + 1) p++;
    return p;
  endfunction

  function automatic bit is_pow2(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  function automatic bit pos_is_data(input int pos);
    return (pos >= 3) && !is_pow2(pos);
  endfunction

  // Payload bit idx lives at the idx-th non-power-of-two position counting from 3.
  function automatic int data_pos(input int idx);
    int cnt;
    int result;
    cnt = 0;
    result = 0;
    for (int pos = 3; pos <= 2 * idx + 16; pos++) begin
      if (pos_is_data(pos)) begin
        if (cnt == idx) result = pos;
        cnt++;
      end
    end
    return result;
  endfunction

  // Stored-word bit index holding Hamming position pos.
  function automatic int pos_to_index(input int pos, input int dataWidth);
    int result;
    result = 0;
    if (pos == 0) begin
      result = dataWidth;
    end else if (is_pow2(pos)) begin
      result = dataWidth + 1 + $clog2(pos);
    end else begin
      for (int q = 3; q < pos; q++) begin
        if (pos_is_data(q)) result++;
      end
    end
    return result;
  endfunction

  function automatic logic [ECC_MAX_MW-1:0] ecc_encode(input logic [ECC_MAX_DW-1:0] data,
                                                       input int dataWidth);
    logic [ECC_MAX_MW-1:0] cw;
    int p;
    int s;
    p = calc_parity_bits(dataWidth);
    cw = '0;
    s = 0;
    for (int i = 0; i < dataWidth; i++) begin
      cw[i] = data[i];
      if (data[i]) s ^= data_pos(i);
    end
    // Check bit 2^k carries bit k of the data syndrome so the full syndrome cancels.
    for (int k = 0; k < p; k++) cw[dataWidth + 1 + k] = s[k];
    cw[dataWidth] = ^cw;
    return cw;
  endfunction

endpackage

// File: rtl/ecc_syndrome_calc.sv
// Combinational Hamming syndrome and overall parity of a stored SEC-DED codeword.
module ecc_syndrome_calc
  import ecc_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int PARITY_BITS       = 6,
  parameter int MEMORY_DATA_WIDTH = 39
) (
  input  logic [MEMORY_DATA_WIDTH-1:0] codeword_i,
  output logic [PARITY_BITS-1:0]       syndrome_o,
  output logic                         parity_o
);

  logic [MEMORY_DATA_WIDTH-1:1] posBits;

  for (genvar pos = 1; pos < MEMORY_DATA_WIDTH; pos++) begin : gPos
    localparam int IDX = pos_to_index(pos, DATA_WIDTH);
    assign posBits[pos] = codeword_i[IDX];
  end

  always_comb begin
    syndrome_o = '0;
    for (int pos = 1; pos < MEMORY_DATA_WIDTH; pos++) begin
      if (posBits[pos]) syndrome_o ^= PARITY_BITS'(pos);
    end
  end

  assign parity_o = ^codeword_i;

endmodule

// File: rtl/ecc_secded_decoder_pipe.sv
// Two-stage pipelined SEC-DED decoder for the sync FIFO read path with
// valid/ready on both sides and saturating corrected/uncorrectable counters.
module ecc_secded_decoder_pipe
  import ecc_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int PARITY_BITS       = 6,
  parameter int MEMORY_DATA_WIDTH = 39,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         ecc_en_i,
  input  logic                         cnt_clr_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [MEMORY_DATA_WIDTH-1:0] rd_data_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [DATA_WIDTH-1:0]        rd_data_dec_o,
  output logic                         sec_err_o,
  output logic                         ded_err_o,
  output logic [PARITY_BITS:0]         syndrome_o,
  output logic [CNT_WIDTH-1:0]         sec_count_o,
  output logic [CNT_WIDTH-1:0]         ded_count_o
);

  if (DATA_WIDTH < 4) begin : gBadDataWidth
    $error("ecc_secded_decoder_pipe: DATA_WIDTH must be at least 4");
  end
  if (PARITY_BITS != calc_parity_bits(DATA_WIDTH)) begin : gBadParityBits
    $error("ecc_secded_decoder_pipe: PARITY_BITS does not match DATA_WIDTH");
  end
  if (MEMORY_DATA_WIDTH != DATA_WIDTH + PARITY_BITS + 1) begin : gBadMemWidth
    $error("ecc_secded_decoder_pipe: MEMORY_DATA_WIDTH must be DATA_WIDTH+PARITY_BITS+1");
  end

  localparam logic [PARITY_BITS-1:0] MAX_POS = PARITY_BITS'(MEMORY_DATA_WIDTH - 1);

  logic [PARITY_BITS-1:0] inSyn;
  logic                   inOp;

  logic                   s1Valid_q, s1Valid_d;
  logic [DATA_WIDTH-1:0]  s1Data_q, s1Data_d;
  logic [PARITY_BITS-1:0] s1Syn_q, s1Syn_d;
  logic                   s1Op_q, s1Op_d;
  logic                   s1En_q, s1En_d;

  logic                   s2Valid_q, s2Valid_d;
  logic [DATA_WIDTH-1:0]  s2Data_q, s2Data_d;
  logic                   s2Sec_q, s2Sec_d;
  logic                   s2Ded_q, s2Ded_d;
  logic [PARITY_BITS:0]   s2Syn_q, s2Syn_d;

  logic [CNT_WIDTH-1:0]   secCount_q, secCount_d;
  logic [CNT_WIDTH-1:0]   dedCount_q, dedCount_d;

  logic                   s2Load, s1Load, inFire, outFire;
  ecc_class_e             eccClass;
  logic [DATA_WIDTH-1:0]  flipMask;
  logic [DATA_WIDTH-1:0]  corrData;

  ecc_syndrome_calc #(
    .DATA_WIDTH       (DATA_WIDTH),
    .PARITY_BITS      (PARITY_BITS),
    .MEMORY_DATA_WIDTH(MEMORY_DATA_WIDTH)
  ) uSynCalc (
    .codeword_i(rd_data_i),
    .syndrome_o(inSyn),
    .parity_o  (inOp)
  );

  assign s2Load     = !s2Valid_q || out_ready_i;
  assign s1Load     = !s1Valid_q || s2Load;
  assign in_ready_o = !rst_i && s1Load;
  assign inFire     = in_valid_i && in_ready_o;
  assign outFire    = s2Valid_q && out_ready_i;

  // Decode class of the word in S1; bypassed words are always reported clean.
  always_comb begin
    eccClass = ECC_CLEAN;
    if (s1En_q) begin
      if (s1Syn_q == '0)       eccClass = s1Op_q ? ECC_SEC : ECC_CLEAN;
      else if (!s1Op_q)        eccClass = ECC_DED;
      else if (s1Syn_q > MAX_POS) eccClass = ECC_DED;
      else                     eccClass = ECC_SEC;
    end
  end

  // A syndrome naming a check-bit position matches no payload bit, leaving data intact.
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : gFlip
    localparam int POS = data_pos(i);
    assign flipMask[i] = (s1Syn_q == PARITY_BITS'(POS));
  end

  assign corrData = s1Data_q ^ ((eccClass == ECC_SEC) ? flipMask : '0);

  always_comb begin
    s1Valid_d  = s1Valid_q;
    s1Data_d   = s1Data_q;
    s1Syn_d    = s1Syn_q;
    s1Op_d     = s1Op_q;
    s1En_d     = s1En_q;
    s2Valid_d  = s2Valid_q;
    s2Data_d   = s2Data_q;
    s2Sec_d    = s2Sec_q;
    s2Ded_d    = s2Ded_q;
    s2Syn_d    = s2Syn_q;
    secCount_d = secCount_q;
    dedCount_d = dedCount_q;

    if (s1Load) begin
      s1Valid_d = inFire;
      if (inFire) begin
        s1Data_d = rd_data_i[DATA_WIDTH-1:0];
        s1Syn_d  = inSyn;
        s1Op_d   = inOp;
        s1En_d   = ecc_en_i;
      end
    end

    if (s2Load) begin
      s2Valid_d = s1Valid_q;
      if (s1Valid_q) begin
        s2Data_d = corrData;
        s2Sec_d  = (eccClass == ECC_SEC);
        s2Ded_d  = (eccClass == ECC_DED);
        s2Syn_d  = {s1Op_q, s1Syn_q};
      end
    end

    // Clear wins over a same-cycle increment.
    if (cnt_clr_i) begin
      secCount_d = '0;
      dedCount_d = '0;
    end else if (outFire) begin
      if (s2Sec_q && secCount_q != '1) secCount_d = secCount_q + CNT_WIDTH'(1);
      if (s2Ded_q && dedCount_q != '1) dedCount_d = dedCount_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1Valid_q  <= 1'b0;
      s1Data_q   <= '0;
      s1Syn_q    <= '0;
      s1Op_q     <= 1'b0;
      s1En_q     <= 1'b0;
      s2Valid_q  <= 1'b0;
      s2Data_q   <= '0;
      s2Sec_q    <= 1'b0;
      s2Ded_q    <= 1'b0;
      s2Syn_q    <= '0;
      secCount_q <= '0;
      dedCount_q <= '0;
    end else begin
      s1Valid_q  <= s1Valid_d;
      s1Data_q   <= s1Data_d;
      s1Syn_q    <= s1Syn_d;
      s1Op_q     <= s1Op_d;
      s1En_q     <= s1En_d;
      s2Valid_q  <= s2Valid_d;
      s2Data_q   <= s2Data_d;
      s2Sec_q    <= s2Sec_d;
      s2Ded_q    <= s2Ded_d;
      s2Syn_q    <= s2Syn_d;
      secCount_q <= secCount_d;
      dedCount_q <= dedCount_d;
    end
  end

  assign out_valid_o   = s2Valid_q;
  assign rd_data_dec_o = s2Data_q;
  assign sec_err_o     = s2Sec_q;
  assign ded_err_o     = s2Ded_q;
  assign syndrome_o    = s2Syn_q;
  assign sec_count_o   = secCount_q;
  assign ded_count_o   = dedCount_q;

endmodule

// File: tb/tb_ecc_secded_decoder_pipe.sv
// Self-checking bench for ecc_secded_decoder_pipe: directed vector table,
// backpressure/reset/counter sequences and a randomized scoreboard run.
module tb_ecc_secded_decoder_pipe;
  import ecc_pkg::*;

  localparam int DW      = 32;
  localparam int PB      = 6;
  localparam int MW      = 39;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, eccEn, cntClr, inValid, outReady;
  logic [MW-1:0] rdData;
  logic          inReady, outValid, secErr, dedErr;
  logic [DW-1:0] decData;
  logic [PB:0]   syndrome;
  logic [CW-1:0] secCount, dedCount;

  ecc_secded_decoder_pipe #(
    .DATA_WIDTH       (DW),
    .PARITY_BITS      (PB),
    .MEMORY_DATA_WIDTH(MW),
    .CNT_WIDTH        (CW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .ecc_en_i     (eccEn),
    .cnt_clr_i    (cntClr),
    .in_valid_i   (inValid),
    .in_ready_o   (inReady),
    .rd_data_i    (rdData),
    .out_valid_o  (outValid),
    .out_ready_i  (outReady),
    .rd_data_dec_o(decData),
    .sec_err_o    (secErr),
    .ded_err_o    (dedErr),
    .syndrome_o   (syndrome),
    .sec_count_o  (secCount),
    .ded_count_o  (dedCount)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          sec;
    logic          ded;
    logic [PB:0]   syn;
  } exp_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [MW-1:0] flip;
    logic          en;
    logic [DW-1:0] expData;
    logic          expSec;
    logic          expDed;
    logic [PB:0]   expSyn;
  } vec_t;

  vec_t  vecs[9];
  exp_t  sbQ[$];
  int    dataPosTab[DW];
  int    checkCount = 0, passCount = 0;
  int    cycleCount = 0, inCount = 0, outCount = 0;
  int    lastInCycle = 0, lastOutCycle = 0;
  int    expSec = 0, expDed = 0;
  logic [DW-1:0] lastData;
  logic          lastSec, lastDed;
  logic [PB:0]   lastSyn;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checkCount++;
    if (act === req) passCount++;
    else $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  function automatic logic [MW-1:0] encodeWord(input logic [DW-1:0] d);
    logic [ECC_MAX_MW-1:0] full;
    full = ecc_encode(ECC_MAX_DW'(d), DW);
    return full[MW-1:0];
  endfunction

  // Decoding rules applied directly: XOR of set-bit positions, overall parity, classify.
  function automatic exp_t modelDecode(input logic [MW-1:0] cw, input logic en);
    exp_t e;
    int   s;
    logic op;
    s  = 0;
    op = ^cw;
    for (int i = 0; i < DW; i++) if (cw[i]) s ^= dataPosTab[i];
    for (int k = 0; k < PB; k++) if (cw[DW+1+k]) s ^= (1 << k);
    e.data = cw[DW-1:0];
    e.sec  = 1'b0;
    e.ded  = 1'b0;
    e.syn  = {op, s[PB-1:0]};
    if (en) begin
      if (s == 0) e.sec = op;
      else if (!op) e.ded = 1'b1;
      else if (s > MW - 1) e.ded = 1'b1;
      else begin
        e.sec = 1'b1;
        for (int i = 0; i < DW; i++) if (dataPosTab[i] == s) e.data[i] = ~e.data[i];
      end
    end
    return e;
  endfunction

  task automatic applyStimulus(input logic [DW-1:0] d, input logic [MW-1:0] flip, input logic en);
    rdData  = encodeWord(d) ^ flip;
    eccEn   = en;
    inValid = 1'b1;
  endtask

  // One clock: compare outputs against the scoreboard, track handshakes, advance.
  task automatic step();
    logic outFire, inFire;
    exp_t e;
    #1;
    if (rst) begin
      checkOutput("inReadyDuringReset", inReady, 0);
      sbQ.delete();
      expSec = 0;
      expDed = 0;
    end else begin
      outFire = outValid && outReady;
      inFire  = inValid && inReady;
      e.data = '0; e.sec = 1'b0; e.ded = 1'b0; e.syn = '0;
      if (outValid) begin
        if (sbQ.size() == 0) checkOutput("unexpectedOutput", 1, 0);
        else begin
          e = sbQ[0];
          checkOutput("outData", decData, e.data);
          checkOutput("outSec", secErr, e.sec);
          checkOutput("outDed", dedErr, e.ded);
          checkOutput("outSyndrome", syndrome, e.syn);
        end
      end
      if (outFire) begin
        lastData     = decData;
        lastSec      = secErr;
        lastDed      = dedErr;
        lastSyn      = syndrome;
        lastOutCycle = cycleCount;
        outCount++;
        if (sbQ.size() > 0) void'(sbQ.pop_front());
      end
      if (cntClr) begin
        expSec = 0;
        expDed = 0;
      end else if (outFire) begin
        if (e.sec && expSec < CNT_MAX) expSec++;
        if (e.ded && expDed < CNT_MAX) expDed++;
      end
      if (inFire) begin
        sbQ.push_back(modelDecode(rdData, eccEn));
        lastInCycle = cycleCount;
        inCount++;
      end
    end
    @(posedge clk);
    cycleCount++;
    #1;
    checkOutput("secCount", secCount, expSec);
    checkOutput("dedCount", dedCount, expDed);
  endtask

  initial begin
    logic [MW-1:0] streamCw[8];
    logic [MW-1:0] flip;
    int pos, idx, guard, startOut, startIn, n;

    pos = 3;
    for (int i = 0; i < DW; i++) begin
      while ((pos & (pos - 1)) == 0) pos++;
      dataPosTab[i] = pos;
      pos++;
    end

    vecs[0] = '{32'hDEADBEEF, 39'h0,            1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 7'h00};
    vecs[1] = '{32'hDEADBEEF, 39'h1,            1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 7'h43};
    vecs[2] = '{32'hDEADBEEF, 39'h01_0000_0000, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 7'h40};
    vecs[3] = '{32'hDEADBEEF, 39'h02_0000_0000, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 7'h41};
    vecs[4] = '{32'h12345678, 39'h21,           1'b1, 32'h12345659, 1'b0, 1'b1, 7'h09};
    vecs[5] = '{32'hDEADBEEF, 39'h1,            1'b0, 32'hDEADBEEE, 1'b0, 1'b0, 7'h43};
    vecs[6] = '{32'hDEADBEEF, 39'h40_0000_0000, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 7'h60};
    vecs[7] = '{32'hDEADBEEF, 39'h41_0000_0008, 1'b1, 32'hDEADBEE7, 1'b0, 1'b1, 7'h67};
    vecs[8] = '{32'hDEADBEEF, 39'h00_8000_0000, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 7'h66};

    rst = 1'b1; eccEn = 1'b1; cntClr = 1'b0; inValid = 1'b0; outReady = 1'b1; rdData = '0;
    @(posedge clk);
    #1;
    step();
    step();
    checkOutput("outValidInReset", outValid, 0);
    rst = 1'b0;
    #1;
    checkOutput("inReadyAfterReset", inReady, 1);

    $display("[TB] directed vector table");
    for (int v = 0; v < 9; v++) begin
      startOut = outCount;
      applyStimulus(vecs[v].data, vecs[v].flip, vecs[v].en);
      step();
      inValid = 1'b0;
      n = 0;
      while (outCount == startOut && n < 8) begin
        step();
        n++;
      end
      if (outCount == startOut) checkOutput("tableTimeout", 0, 1);
      else begin
        checkOutput("tableLatency", lastOutCycle - lastInCycle, 2);
        checkOutput("tableData", lastData, vecs[v].expData);
        checkOutput("tableSec", lastSec, vecs[v].expSec);
        checkOutput("tableDed", lastDed, vecs[v].expDed);
        checkOutput("tableSyndrome", lastSyn, vecs[v].expSyn);
      end
    end
    checkOutput("secAfterTable", secCount, 5);
    checkOutput("dedAfterTable", dedCount, 2);

    $display("[TB] toggling backpressure stream");
    for (int i = 0; i < 8; i++) begin
      flip = '0;
      if (i % 2 == 1) flip[$urandom_range(0, MW - 1)] = 1'b1;
      streamCw[i] = encodeWord($urandom) ^ flip;
    end
    idx = 0; guard = 0; startOut = outCount;
    eccEn = 1'b1;
    while ((idx < 8 || sbQ.size() > 0) && guard < 100) begin
      outReady = (guard % 2 == 0);
      inValid  = (idx < 8);
      if (idx < 8) rdData = streamCw[idx];
      startIn = inCount;
      step();
      if (inCount != startIn) idx++;
      guard++;
    end
    inValid = 1'b0;
    checkOutput("toggleStreamCount", outCount - startOut, 8);

    $display("[TB] reset mid-stream");
    outReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus($urandom, '0, 1'b1);
      step();
    end
    inValid = 1'b0;
    rst = 1'b1;
    step();
    checkOutput("outValidAfterMidReset", outValid, 0);
    checkOutput("secAfterMidReset", secCount, 0);
    checkOutput("dedAfterMidReset", dedCount, 0);
    rst = 1'b0;
    #1;
    checkOutput("inReadyAfterMidReset", inReady, 1);
    outReady = 1'b1;
    step();
    checkOutput("noStaleOutput", outValid, 0);

    $display("[TB] counter saturation");
    for (int i = 0; i < CNT_MAX + 3; i++) begin
      applyStimulus($urandom, 39'h6, 1'b1);
      step();
    end
    inValid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    checkOutput("dedSaturated", dedCount, CNT_MAX);

    $display("[TB] clear against a same-cycle increment");
    applyStimulus(32'hA5A5A5A5, 39'h4, 1'b1);
    step();
    inValid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    outReady = 1'b0;
    applyStimulus(32'h5A5A5A5A, 39'h4, 1'b1);
    step();
    inValid = 1'b0;
    step();
    step();
    checkOutput("secPendingValid", outValid, 1);
    outReady = 1'b1;
    cntClr   = 1'b1;
    step();
    cntClr = 1'b0;
    checkOutput("secClearedWins", secCount, 0);
    checkOutput("dedClearedWins", dedCount, 0);

    applyStimulus(32'hCAFEF00D, 39'h10, 1'b0);
    step();
    inValid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    checkOutput("bypassSecUnchanged", secCount, 0);
    checkOutput("bypassDedUnchanged", dedCount, 0);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 400; c++) begin
      flip = '0;
      n = $urandom_range(0, 3);
      for (int j = 0; j < n; j++) flip[$urandom_range(0, MW - 1)] ^= 1'b1;
      rdData   = encodeWord($urandom) ^ flip;
      eccEn    = ($urandom_range(0, 7) != 0);
      inValid  = $urandom_range(0, 1);
      outReady = ($urandom_range(0, 3) != 0);
      cntClr   = ($urandom_range(0, 31) == 0);
      step();
    end
    inValid = 1'b0; cntClr = 1'b0; outReady = 1'b1;
    guard = 0;
    while (sbQ.size() > 0 && guard < 10) begin
      step();
      guard++;
    end
    checkOutput("drainEmpty", sbQ.size(), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
